// File: rtl/landing_scanner.sv
// landing_scanner
// Once per frame, walks the 90-entry platform table one entry per clock and
// decides whether the falling doodle lands on a platform this frame. The
// first matching platform in index order wins. The result is published in a
// single update at the end of the walk and then held until the next walk
// completes.
//
// Ports
//   clk                  system clock
//   rst                  asynchronous reset, active low
//   fps_counter          frame cycle counter; a value of zero starts a scan
//   platforms            per platform: [0] = top y, [1] = left x (signed)
//   platform_activation  per-platform solid flag
//   doodle_x/doodle_y    doodle top-left corner
//   doodle_falling       doodle vertical velocity points downward
//   scan_busy            scan in progress
//   hit_valid            last completed scan found a landing
//   hit_index            index of the landed platform
//   landing_y            snapped doodle top y (platform y - DOODLE_H)
//   move_collision       landing is above the scroll line; scroll requested
//
// state | meaning
// IDLE  | waiting for fps_counter == 0, outputs holding the last result
// SCAN  | evaluating platform r_idx, one per cycle, 0..89
// DONE  | publishing the pending result to the outputs
module landing_scanner #(
    parameter int FPS         = 60,
    parameter int CLK         = 25_000_000,
    parameter int DOODLE_W    = 80,
    parameter int DOODLE_H    = 80,
    parameter int PLAT_W      = 100,
    parameter int PLAT_H      = 30,
    parameter int TOL         = 12,
    parameter int SCROLL_LINE = 300
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(CLK/FPS):0]      fps_counter,
    input  logic signed [89:0][1:0][10:0] platforms,
    input  logic [89:0]                   platform_activation,
    input  logic [10:0]                   doodle_x,
    input  logic [9:0]                    doodle_y,
    input  logic                          doodle_falling,
    output logic                          scan_busy,
    output logic                          hit_valid,
    output logic [6:0]                    hit_index,
    output logic signed [10:0]            landing_y,
    output logic                          move_collision
);

    if (CLK / FPS < 94) begin : g_bad_rate
        $error("landing_scanner: a frame must last at least 94 clocks");
    end
    if (PLAT_H < 1) begin : g_bad_plat_h
        $error("landing_scanner: platform height must be positive");
    end

    localparam logic signed [11:0] C_DW_M1  = 12'(DOODLE_W - 1);
    localparam logic signed [11:0] C_PW_M1  = 12'(PLAT_W - 1);
    localparam logic signed [11:0] C_DH     = 12'(DOODLE_H);
    localparam logic signed [11:0] C_TOL_M1 = 12'(TOL - 1);
    localparam logic signed [10:0] C_SCROLL = 11'(SCROLL_LINE);
    localparam logic [6:0]         C_LAST   = 7'd89;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [6:0]         r_idx;
    logic [10:0]        r_dx;
    logic [9:0]         r_dy;
    logic               r_falling;
    logic               r_found;
    logic [6:0]         r_found_idx;
    logic signed [10:0] r_found_y;

    logic [10:0]        w_py_raw;
    logic [10:0]        w_px_raw;
    logic signed [11:0] w_py;
    logic signed [11:0] w_px;
    logic signed [11:0] w_dx;
    logic signed [11:0] w_feet;
    logic signed [11:0] w_land;
    logic               w_hit;

    // Slices of a packed array come back unsigned, so sign-extend by hand.
    assign w_py_raw = platforms[r_idx][0];
    assign w_px_raw = platforms[r_idx][1];
    assign w_py     = {w_py_raw[10], w_py_raw};
    assign w_px     = {w_px_raw[10], w_px_raw};
    assign w_dx     = {1'b0, r_dx};
    assign w_feet   = $signed({2'b00, r_dy}) + C_DH;
    assign w_land   = w_py - C_DH;

    assign w_hit = platform_activation[r_idx] && r_falling
                && (w_dx + C_DW_M1 >= w_px)
                && (w_dx <= w_px + C_PW_M1)
                && (w_py <= w_feet)
                && (w_feet <= w_py + C_TOL_M1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_dx           <= '0;
            r_dy           <= '0;
            r_falling      <= 1'b0;
            r_found        <= 1'b0;
            r_found_idx    <= '0;
            r_found_y      <= '0;
            scan_busy      <= 1'b0;
            hit_valid      <= 1'b0;
            hit_index      <= '0;
            landing_y      <= '0;
            move_collision <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fps_counter == '0) begin
                        r_state     <= S_SCAN;
                        r_idx       <= '0;
                        r_dx        <= doodle_x;
                        r_dy        <= doodle_y;
                        r_falling   <= doodle_falling;
                        r_found     <= 1'b0;
                        r_found_idx <= '0;
                        r_found_y   <= '0;
                        scan_busy   <= 1'b1;
                    end
                end
                S_SCAN: begin
                    // Only the first hit is kept; later ones leave the pending result alone.
                    if (w_hit && !r_found) begin
                        r_found     <= 1'b1;
                        r_found_idx <= r_idx;
                        r_found_y   <= w_land[10:0];
                    end
                    if (r_idx == C_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 7'd1;
                    end
                end
                S_DONE: begin
                    r_state        <= S_IDLE;
                    r_idx          <= '0;
                    scan_busy      <= 1'b0;
                    hit_valid      <= r_found;
                    hit_index      <= r_found_idx;
                    landing_y      <= r_found_y;
                    move_collision <= r_found && (r_found_y < C_SCROLL);
                end
                default: begin
                    r_state   <= S_IDLE;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/landing_scanner.md
LANDING_SCANNER -- requirements
Module: landing_scanner

Interface
REQ-001 Parameter FPS, default 60, frame rate; together with CLK it sets the fps_counter width.
REQ-002 Parameter CLK, default 25_000_000, clock frequency in Hz; CLK/FPS SHALL be >= 94.
REQ-003 Parameter DOODLE_W, default 80, doodle sprite width in pixels.
REQ-004 Parameter DOODLE_H, default 80, doodle sprite height in pixels.
REQ-005 Parameters PLAT_W = 100 and PLAT_H = 30, platform sprite size in pixels.
REQ-006 Parameter TOL, default 12, vertical landing window depth in pixels.
REQ-007 Parameter SCROLL_LINE, default 300, landing y below which a scroll is requested.
REQ-008 clk  in  1  single system clock; all state on posedge clk.
REQ-009 rst  in  1  asynchronous, active-low reset (rst=0 resets).
REQ-010 fps_counter  in  $clog2(CLK/FPS)+1  free-running frame cycle counter.
REQ-011 platforms  in  [89:0][1:0][10:0] signed  per platform: [0] = top y, [1] = left x.
REQ-012 platform_activation  in  90  per-platform visible/solid flag.
REQ-013 doodle_x  in  11  doodle left x.
REQ-014 doodle_y  in  10  doodle top y.
REQ-015 doodle_falling  in  1  1 when vertical velocity is downward.
REQ-016 scan_busy  out  1  high while the scan is in progress.
REQ-017 hit_valid  out  1  last completed scan found a landing.
REQ-018 hit_index  out  7  index of the landed platform.
REQ-019 landing_y  out  11 signed  snapped doodle top y, equal to platform y - DOODLE_H.
REQ-020 move_collision  out  1  scroll request, consumed by the platform stage when fps_counter is all-ones.

Function
REQ-021 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-022 IDLE -> SCAN when fps_counter == 0 (the cycle after the platform update): snapshot doodle_x, doodle_y and doodle_falling, and set idx = 0.
REQ-023 In SCAN, the block SHALL evaluate platform idx once per cycle, for idx 0..89 over 90 cycles; SCAN -> DONE after idx 89.
REQ-024 DONE -> IDLE after one cycle; the result registers SHALL load on that edge.
REQ-025 Result latency: fps_counter==0 at cycle t means outputs are valid from cycle t+92.
REQ-026 Result outputs SHALL hold constant until the next DONE, so they are stable when fps_counter is all-ones.
REQ-027 Hit condition for platform i, using the snapshot values and 12-bit signed arithmetic:
- activation[i] = 1
- falling = 1
- doodle_x + DOODLE_W - 1 >= px
- doodle_x <= px + PLAT_W - 1
- py <= doodle_y + DOODLE_H <= py + TOL - 1
REQ-028 Priority: the first hit in scan order (lowest index) wins; later hits in the same scan SHALL be ignored.
REQ-029 On a hit: hit_valid = 1, hit_index = i, landing_y = py - DOODLE_H, move_collision = (landing_y < SCROLL_LINE, signed compare).
REQ-030 On no hit: hit_valid = 0, hit_index = 0, landing_y = 0, move_collision = 0.
REQ-031 scan_busy SHALL be 1 in SCAN and DONE, and 0 in IDLE.
REQ-032 fps_counter == 0 seen while not in IDLE SHALL be ignored; no restart.
REQ-033 Platforms with negative y (above the screen) SHALL be evaluated with correct signed compares; no wrap-around.
REQ-034 Changes to the doodle inputs during SCAN SHALL NOT affect the current scan.

Reset
REQ-035 rst = 0 SHALL immediately force FSM = IDLE, idx = 0, the snapshot registers to 0, and every output to 0.
REQ-036 Reset mid-scan SHALL abort the scan with no partial result; the first scan after release starts at the next fps_counter == 0.

Verification (DOODLE_W = 80, DOODLE_H = 80, TOL = 12, SCROLL_LINE = 300)
REQ-037 Basic hit: platform 5 at y = 400, x = 342, active; doodle (360, 322), falling; fps_counter 0 at t -> at t+92 hit_valid = 1, hit_index = 5, landing_y = 320, move_collision = 0; scan_busy high t+1..t+91.
REQ-038 Scroll request: platform 5 at y = 250; doodle_y = 172 -> landing_y = 170, move_collision = 1, held through fps_counter all-ones.
REQ-039 Rising doodle and inactive platform: same geometry with doodle_falling = 0 -> hit_valid = 0, all outputs 0; same with activation[5] = 0 -> no hit.
REQ-040 Priority and edges:
- platforms 7 and 40 both satisfy the hit condition -> hit_index = 7.
- doodle_x = 263 with px = 342 -> hit; doodle_x = 262 -> miss.
- feet = py + 11 -> hit; feet = py + 12 -> miss.
REQ-041 Index 89 only hitting -> hit_index = 89, result at t+92.
REQ-042 rst pulsed low at scan cycle 45 -> outputs 0 and scan_busy 0 at once; next fps_counter == 0 gives a normal full scan with correct result.
